instruction_fetch_responder: RTL

- Instruction-memory side of the program-counter interface. It samples the current PC on a fetch request and returns the addressed instruction after a fixed number of wait states.
- While the fetch is outstanding it holds PCWriteEnable low, which stalls the PC register. It pulses PCWriteEnable for one cycle when the instruction is delivered, or when a flush redirects fetch.
- Sits between the PC register and the IF/ID pipeline register in the MIPS datapath.

---
 rtl/pc_fetch_pkg.sv | 25 ++
 rtl/instr_rom.sv | 28 ++
 rtl/instruction_fetch_responder.sv | 103 ++++++++++
 3 files changed

// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the instruction-fetch responder: FSM encoding,
// default limits and the address-check helper.
package pc_fetch_pkg;

  // Word index width of the instruction ROM (2048 bytes / 4).
  localparam int unsigned ROM_IDX_W = 9;

  // Default byte-address bound; any PC at or above it is out of range.
  localparam int unsigned ADDR_LIMIT_DEF = 2048;

  // Word delivered in place of ROM data when the captured PC is bad.
  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } fetch_state_e;

  // A fetch address is bad if it is out of range or not word aligned.
  function automatic logic addr_bad(input logic [31:0] addr, input logic [31:0] limit);
    return (addr >= limit) || (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/instr_rom.sv
// Instruction ROM: synchronous write port for boot/bench loading and an
// asynchronous read port. A write at the same edge as a registered read
// returns the old word, since the read is sampled before the write lands.
module instr_rom
  import pc_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 512
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ROM_IDX_W-1:0] waddr,
  input  logic [31:0]          wdata,
  input  logic [ROM_IDX_W-1:0] raddr,
  output logic [31:0]          rdata
);

  logic [31:0] mem [DEPTH];

  // Load port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_fetch_responder.sv
// Instruction-memory side of the PC interface. Captures the PC on a fetch
// request, waits WAIT_STATES cycles, then presents the addressed word for a
// single cycle together with a PC write-enable pulse. The PC is stalled
// (write-enable low) for the whole fetch. A flush drops any pending fetch
// and pulses the write-enable so the PC can take the redirect target.
module instruction_fetch_responder
  import pc_fetch_pkg::*;
#(
  parameter int unsigned ADDR_LIMIT  = ADDR_LIMIT_DEF,
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned DEPTH       = 512,
  parameter logic [31:0] NOP_WORD    = NOP_WORD_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          pc,
  input  logic                 fetch_req,
  input  logic                 flush_req,
  input  logic                 load_en,
  input  logic [ROM_IDX_W-1:0] load_addr,
  input  logic [31:0]          load_data,
  output logic [31:0]          instruction,
  output logic                 instr_valid,
  output logic [31:0]          response_pc,
  output logic                 addr_error,
  output logic                 pc_write_enable
);

  localparam logic [3:0] WaitInit = 4'(WAIT_STATES);

  fetch_state_e state_q;
  logic [3:0]   cnt_q;
  logic [31:0]  addr_q;
  logic [31:0]  rom_rdata;
  logic         addr_err;

  assign addr_err = addr_bad(addr_q, ADDR_LIMIT);

  instr_rom #(
    .DEPTH(DEPTH)
  ) u_rom (
    .clk  (clk),
    .we   (load_en),
    .waddr(load_addr),
    .wdata(load_data),
    .raddr(addr_q[ROM_IDX_W+1:2]),
    .rdata(rom_rdata)
  );

  // Fetch FSM with registered outputs. StResp is the single cycle in which
  // the ROM word is read; the edge leaving it registers the response, so the
  // response cycle coincides with the first IDLE cycle and a new request can
  // already be accepted there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      addr_q          <= '0;
      instruction     <= '0;
      response_pc     <= '0;
      instr_valid     <= 1'b0;
      addr_error      <= 1'b0;
      pc_write_enable <= 1'b0;
    end else begin
      instr_valid     <= 1'b0;
      pc_write_enable <= 1'b0;
      if (flush_req) begin
        // Redirect wins over everything, including a same-cycle request.
        state_q         <= StIdle;
        cnt_q           <= '0;
        pc_write_enable <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (fetch_req) begin
              addr_q  <= pc;
              cnt_q   <= WaitInit;
              state_q <= (WAIT_STATES == 0) ? StResp : StWait;
            end
          end
          StWait: begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              state_q <= StResp;
            end
          end
          StResp: begin
            instruction     <= addr_err ? NOP_WORD : rom_rdata;
            response_pc     <= addr_q;
            addr_error      <= addr_err;
            instr_valid     <= 1'b1;
            pc_write_enable <= 1'b1;
            state_q         <= StIdle;
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

endmodule
